// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin arbiter sharing one UART transmitter between NUM_REQ
//           byte producers; optional tx_done watchdog via UART_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_en,
  output logic [DATA_W-1:0]          data_in,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       tx_timeout
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [GW-1:0]       last_grant, last_grant_nxt;
  logic [GW-1:0]       grant_id_nxt;
  logic [DATA_W-1:0]   data_in_nxt;
  logic [NUM_REQ-1:0]  req_ready_nxt;
  logic                tx_en_nxt;
  logic                busy_nxt;
  logic                found;
  logic [GW-1:0]       pick;

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]         wd, wd_nxt;
  logic                tx_timeout_nxt;
`endif

  // Rotating priority: scan starts just after the previous winner.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    data_in_nxt    = data_in;
    req_ready_nxt  = '0;
    tx_en_nxt      = 1'b0;
    busy_nxt       = busy;
`ifdef UART_ARB_TIMEOUT_EN
    wd_nxt         = wd;
    tx_timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          data_in_nxt    = req_data[int'(pick)*DATA_W +: DATA_W];
          grant_id_nxt   = pick;
          last_grant_nxt = pick;
          req_ready_nxt  = NUM_REQ'(1) << pick;
          tx_en_nxt      = 1'b1;
          busy_nxt       = 1'b1;
          state_nxt      = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
          wd_nxt         = '0;
`endif
        end
      end
      WAIT: begin
        // tx_done coinciding with our own start pulse belongs to an older frame
        if (tx_done && !tx_en) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (wd == 32'(TIMEOUT_CYCLES - 1)) begin
          tx_timeout_nxt = 1'b1;
          busy_nxt       = 1'b0;
          state_nxt      = IDLE;
        end else begin
          wd_nxt = wd + 32'd1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      data_in    <= '0;
      req_ready  <= '0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
      data_in    <= data_in_nxt;
      req_ready  <= req_ready_nxt;
      tx_en      <= tx_en_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd         <= '0;
      tx_timeout <= 1'b0;
    end else begin
      wd         <= wd_nxt;
      tx_timeout <= tx_timeout_nxt;
    end
  end
`else
  assign tx_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed scoreboard bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TMO     = 16;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_en;
  logic [DATA_W-1:0]         data_in;
  logic                      tx_done;
  logic [1:0]                grant_id;
  logic                      busy;
  logic                      tx_timeout;

  typedef struct {
    int          gid;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_en(tx_en),
    .data_in(data_in),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .busy(busy),
    .tx_timeout(tx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int gid, input logic [7:0] data);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    sb.push_back(e);
  endtask

  // Waits for tx_en (bounded), then compares the grant against the scoreboard head.
  task automatic expect_grant(input int max_cycles, output int cycles);
    exp_t e;
    cycles = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      cycles = c;
      if (tx_en === 1'b1) break;
    end
    check("tx_en_seen", {31'd0, tx_en}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, {31'd0, tx_en} - 32'd1);
    end else begin
      e = sb.pop_front();
      check("data_in", {24'd0, data_in}, {24'd0, e.data});
      check("grant_id", {30'd0, grant_id}, 32'(e.gid));
      check("req_ready", {28'd0, req_ready}, 32'd1 << e.gid);
      check("busy_on_grant", {31'd0, busy}, 32'd1);
    end
  endtask

  // Frame in flight: no further start or accept pulses, busy stays high.
  task automatic hold_wait(input int n, input bit scramble);
    int spurious = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || req_ready !== '0 || busy !== 1'b1) spurious++;
      if (scramble) req_valid = NUM_REQ'($urandom);
    end
    if (scramble) req_valid = '0;
    check("wait_quiet", 32'(spurious), 32'd0);
  endtask

  task automatic finish_frame();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_check(input int n);
    int activity = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || req_ready !== '0 || busy !== 1'b0) activity++;
    end
    check("idle_quiet", 32'(activity), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_data_in", {24'd0, data_in}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_timeout", {31'd0, tx_timeout}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request, one-cycle latency
    req_valid        = 4'b0001;
    req_data[7:0]    = 8'hA5;
    push(0, 8'hA5);
    expect_grant(4, cyc);
    check("latency", 32'(cyc), 32'd1);
    req_valid = '0;
    hold_wait(20, 1'b0);
    finish_frame();

    // All requesters held: order 0,1,2,3,0 with 2-cycle tx_done->tx_en gap
    do_reset();
    req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_valid = 4'b1111;
    push(0, 8'hA0); push(1, 8'hB1); push(2, 8'hC2); push(3, 8'hD3); push(0, 8'hA0);
    expect_grant(4, cyc);
    check("rr_latency", 32'(cyc), 32'd1);
    for (int f = 0; f < 5; f++) begin
      hold_wait(6, 1'b0);
      if (f == 4) req_valid = '0;
      finish_frame();
      if (f < 4) begin
        expect_grant(4, cyc);
        check("rr_gap", 32'(cyc + 1), 32'd2);
      end
    end

    // Only requester 2, three consecutive bytes
    req_valid       = 4'b0100;
    req_data[23:16] = 8'h11;
    push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
    expect_grant(4, cyc);
    req_data[23:16] = 8'h22;
    hold_wait(4, 1'b0);
    finish_frame();
    expect_grant(4, cyc);
    req_data[23:16] = 8'h33;
    hold_wait(4, 1'b0);
    finish_frame();
    expect_grant(4, cyc);
    req_valid = '0;
    hold_wait(4, 1'b0);
    finish_frame();

    // tx_done in IDLE is ignored; data_in/grant_id hold
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    idle_check(4);
    check("hold_data_in", {24'd0, data_in}, 32'h33);
    check("hold_grant_id", {30'd0, grant_id}, 32'd2);

    // req_valid churn during WAIT is ignored
    req_valid       = 4'b1000;
    req_data[31:24] = 8'h3C;
    push(3, 8'h3C);
    expect_grant(4, cyc);
    req_valid = '0;
    hold_wait(10, 1'b1);
    finish_frame();
    idle_check(4);

    // Reset mid-frame; unacknowledged requester 1 re-arbitrated from 0
    req_valid      = 4'b0011;
    req_data[7:0]  = 8'h0F;
    req_data[15:8] = 8'h5C;
    push(0, 8'h0F);
    expect_grant(4, cyc);
    req_valid = 4'b0010;
    hold_wait(5, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_tx_en", {31'd0, tx_en}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data_in", {24'd0, data_in}, 32'd0);
    check("mid_rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
    reset = 1'b0;
    push(1, 8'h5C);
    expect_grant(4, cyc);
    check("post_rst_latency", 32'(cyc), 32'd1);
    req_valid = '0;
    hold_wait(3, 1'b0);
    finish_frame();

    // tx_done withheld
    req_valid       = 4'b1000;
    req_data[31:24] = 8'hE7;
    push(3, 8'hE7);
    expect_grant(4, cyc);
    req_valid = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
`ifdef UART_ARB_TIMEOUT_EN
      check("tmo_pulse", {31'd0, tx_timeout}, (k == TMO) ? 32'd1 : 32'd0);
      check("tmo_busy", {31'd0, busy}, (k < TMO) ? 32'd1 : 32'd0);
`else
      check("tmo_pulse", {31'd0, tx_timeout}, 32'd0);
      check("tmo_busy", {31'd0, busy}, 32'd1);
`endif
    end
`ifndef UART_ARB_TIMEOUT_EN
    finish_frame();
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
- Accepts one byte per requester through a valid/ready handshake.
- Presents the granted byte on the UART data_in, pulses tx_en, then holds off further grants until the UART reports frame completion on tx_done.
- Sits between the requester blocks and the UART TX datapath (tx_en, data_in, tx).

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 8: byte width; must match UART data_in.
- TIMEOUT_CYCLES, 4096: watchdog limit in clk cycles for tx_done. Only used with UART_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte-valid.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
- tx_en  output  1  one-cycle start pulse to the UART transmitter.
- data_in  output  DATA_W  byte to the UART transmitter.
- tx_done  input  1  one-cycle pulse from the UART at the end of the stop bit.
- grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current or last frame.
- busy  output  1  high while a frame is owned.
- tx_timeout  output  1  one-cycle watchdog abort pulse. Tied 0 without the macro.

Behaviour:
- Reset (checked on clk rising edge, reset=1):
  - Outputs: tx_en=0, req_ready=0, data_in=0, grant_id=0, busy=0, tx_timeout=0.
  - State: state=IDLE, last_grant=NUM_REQ-1, so requester 0 wins first.
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE:
  - If any req_valid is high, select the first valid index scanning last_grant+1, last_grant+2, ... mod NUM_REQ.
  - At the next edge: data_in<=req_data[g], grant_id<=g, last_grant<=g, req_ready[g]<=1, tx_en<=1, busy<=1, go to WAIT.
  - If no req_valid is high, stay in IDLE with outputs unchanged.
- WAIT:
  - req_ready and tx_en return to 0 after exactly one cycle.
  - On tx_done=1 (ignored in the cycle tx_en is high), at the next edge: busy<=0, go to IDLE.
  - req_valid is ignored while in WAIT.
- Latency: req_valid high in cycle t gives tx_en and req_ready high in cycle t+1.
- Minimum gap: one IDLE cycle after tx_done before the next tx_en. Back-to-back frames from different requesters are therefore spaced tx_done -> +2 cycles -> tx_en.
- data_in and grant_id hold their value until the next grant. They are never cleared except by reset.
- Handshake rules:
  - Requester i must hold req_data stable while req_valid[i]=1 and req_ready[i]=0.
  - Retracting req_valid before ready is allowed; an arbitration decision already registered is not undone.
- tx_done while in IDLE: ignored, no state change.
- Simultaneous tx_done and a new req_valid in WAIT: the frame completes first. The new request is arbitrated in the following IDLE cycle.
- Single-requester case: the same requester may win consecutively when no other requester is valid.
- Reset mid-frame: immediate return to IDLE with all outputs zero. A requester that already saw req_ready has lost its byte. A requester not yet acknowledged keeps req_valid and is re-arbitrated from requester 0.

Optional Feature:
- UART_ARB_TIMEOUT_EN defined:
  - A 32-bit watchdog counter clears on tx_en and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES-1 without tx_done: tx_timeout=1 for one cycle, busy<=0, go to IDLE.
  - last_grant keeps the aborted requester, so the next grant moves on.
  - tx_done arriving in the same cycle as expiry wins: no timeout pulse.
- UART_ARB_TIMEOUT_EN undefined:
  - No counter is instantiated; tx_timeout is constant 0.
  - WAIT waits indefinitely for tx_done.

Test Plan:
- After reset, req_valid=4'b0001, req_data[7:0]=8'hA5 -> one cycle later tx_en=1, data_in=8'hA5, req_ready=4'b0001, grant_id=0, busy=1. tx_done 20 cycles later -> busy=0 the next cycle.
- req_valid=4'b1111 held continuously, each frame completed by tx_done -> grant order 0,1,2,3,0. No tx_en while busy. Gap tx_done->tx_en is exactly 2 cycles.
- Only requester 2 valid for three frames, bytes 8'h11, 8'h22, 8'h33 -> grant_id=2 three times. data_in sequence is 11, 22, 33.
- tx_done pulse in IDLE, and req_valid changes during WAIT -> no state change, no extra tx_en, no extra req_ready.
- reset asserted 5 cycles into WAIT with requester 1 still valid -> all outputs 0 the next cycle. After reset release, requester 1 is granted with its current byte.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, tx_done withheld -> tx_timeout=1 exactly 16 cycles after tx_en, busy=0. Without the macro, tx_timeout stays 0 and busy stays 1.
